// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types, constants and helpers for the multiplier share arbiter
package mul_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int next_idx(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - 16-bit unsigned integer / FP16 multiplier with error flag
module fp_mul (
    input  logic        mode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        error
);

    logic [31:0]       int_prod;
    logic [21:0]       sig_prod;
    logic [21:0]       sig_norm;
    logic [11:0]       sig_rnd;
    logic              norm;
    logic              rnd_up;
    logic              sign;
    logic              a_zero, b_zero, a_spec, b_spec;
    logic signed [7:0] exp_sum;
    logic [9:0]        mant;

    // FP16 path: subnormals flush to zero, round-to-nearest-even, overflow and inf/NaN inputs flag error
    always_comb begin
        int_prod = {16'b0, a} * {16'b0, b};
        sign     = a[15] ^ b[15];
        a_zero   = (a[14:10] == 5'h00);
        b_zero   = (b[14:10] == 5'h00);
        a_spec   = (a[14:10] == 5'h1f);
        b_spec   = (b[14:10] == 5'h1f);
        sig_prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        norm     = sig_prod[21];
        sig_norm = norm ? sig_prod : {sig_prod[20:0], 1'b0};
        rnd_up   = sig_norm[10] & (sig_norm[11] | (|sig_norm[9:0]));
        sig_rnd  = {1'b0, sig_norm[21:11]} + {11'b0, rnd_up};
        exp_sum  = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15
                 + $signed({7'b0, norm}) + $signed({7'b0, sig_rnd[11]});
        mant     = sig_rnd[11] ? sig_rnd[10:1] : sig_rnd[9:0];

        result = 16'h0000;
        error  = 1'b0;
        if (!mode) begin
            result = int_prod[15:0];
            error  = |int_prod[31:16];
        end else if (a_spec || b_spec) begin
            result = 16'h7e00;
            error  = 1'b1;
        end else if (a_zero || b_zero) begin
            result = {sign, 15'b0};
        end else if (exp_sum >= 8'sd31) begin
            result = {sign, 5'h1f, 10'b0};
            error  = 1'b1;
        end else if (exp_sum <= 8'sd0) begin
            result = {sign, 15'b0};
        end else begin
            result = {sign, exp_sum[4:0], mant};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority search starting at rr_ptr
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
            idx = ID_W'(next_idx(int'(idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one fp_mul among NUM_REQ requesters
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ERR_CNT_W = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_mode,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_error,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output logic                      busy
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
    logic                  mode_q, mode_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic                  error_q, error_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic                  grant_valid;
    logic [ID_W-1:0]       grant_idx;
    logic [DATA_W-1:0]     mul_result;
    logic                  mul_error;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    fp_mul u_fp_mul (
        .mode   (mode_q),
        .a      (a_q),
        .b      (b_q),
        .result (mul_result),
        .error  (mul_error)
    );

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        id_d        = id_q;
        result_d    = result_q;
        error_d     = error_q;
        rsp_valid_d = rsp_valid_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    a_d      = req_a[int'(grant_idx)*DATA_W +: DATA_W];
                    b_d      = req_b[int'(grant_idx)*DATA_W +: DATA_W];
                    mode_d   = req_mode[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = ID_W'(next_idx(int'(grant_idx), NUM_REQ));
                    state_d  = CALC;
                end
            end
            CALC: begin
                result_d    = mul_result;
                error_d     = mul_error;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (error_q && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            id_q        <= '0;
            result_q    <= '0;
            error_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            result_q    <= result_d;
            error_q     <= error_d;
            rsp_valid_q <= rsp_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_error  = error_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int ERR_CNT_W = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_error;
    logic [ERR_CNT_W-1:0]  err_cnt;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ERR_CNT_W(ERR_CNT_W), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request and completes it with rsp_ready high; ok=0 on a timed-out wait.
    task automatic run_op(input int idx, input logic m, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic err, output logic [ID_W-1:0] id,
                          output bit ok);
        bit got;
        ok = 1'b0; res = '0; err = 1'b0; id = '0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_mode[idx] = m;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            @(negedge clk);
        end
        req_valid = '0;
        if (!got) return;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (rsp_valid) begin
                res = rsp_result; err = rsp_error; id = rsp_id; got = 1'b1;
            end
            @(negedge clk);
        end
        ok = got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (rsp_result !== 16'h0000 || rsp_id !== 2'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_regs got %h/%0d/%0b exp 0/0/0", rsp_result, rsp_id, rsp_error); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL early_rsp_ready got valid %0b busy %0b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_single_fp16();
        rsp_ready = 1'b1;
        req_mode[0] = 1'b1; req_a[15:0] = 16'h4000; req_b[15:0] = 16'h4200;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_calc got busy %0b valid %0b ready %b exp 1 0 0000", busy, rsp_valid, req_ready); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0b exp 1", rsp_valid); end
        checks++; if (rsp_result !== 16'h4600) begin errors++; $display("FAIL single_result got %h exp 4600", rsp_result); end
        checks++; if (rsp_id !== 2'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL single_id_err got %0d/%0b exp 0/0", rsp_id, rsp_error); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got valid %0b busy %0b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy;
        logic [15:0] exp_res;
        int          who;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_mode[i] = 1'b0;
            req_a[i*16 +: 16] = 16'(i + 1);
            req_b[i*16 +: 16] = 16'd3;
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            who = (c / 3) % 4;
            exp_rdy = (c % 3 == 0) ? (4'b0001 << who) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cycle %0d got %b exp %b", c, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== (c % 3 == 2)) begin errors++; $display("FAIL rr_rsp_valid cycle %0d got %0b exp %0b", c, rsp_valid, (c % 3 == 2)); end
            if (c % 3 == 2) begin
                exp_res = 16'(3 * (who + 1));
                checks++; if (rsp_id !== 2'(who) || rsp_result !== exp_res) begin errors++; $display("FAIL rr_rsp cycle %0d got id %0d res %0d exp id %0d res %0d", c, rsp_id, rsp_result, who, exp_res); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_mode[1] = 1'b0; req_a[31:16] = 16'd100; req_b[31:16] = 16'd7;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_calc_ready got %b exp 0000", req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd700 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_hold cycle %0d got valid %0b res %0d id %0d exp 1 700 1", k, rsp_valid, rsp_result, rsp_id); end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall cycle %0d got ready %b busy %0b exp 0000 1", k, req_ready, busy); end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_release got valid %0b busy %0b ready %b exp 0 0 0000", rsp_valid, busy, req_ready); end
    endtask

    task automatic test_fairness();
        rsp_ready = 1'b1;
        req_mode[2] = 1'b0; req_a[47:32] = 16'd5; req_b[47:32] = 16'd5;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_first got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_id !== 2'd2 || rsp_result !== 16'd25) begin errors++; $display("FAIL fair_rsp2a got id %0d res %0d exp 2 25", rsp_id, rsp_result); end
        @(negedge clk);
        req_mode[0] = 1'b0; req_a[15:0] = 16'd9; req_b[15:0] = 16'd2;
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_pick0 got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        #1;
        checks++; if (rsp_id !== 2'd0 || rsp_result !== 16'd18) begin errors++; $display("FAIL fair_rsp0 got id %0d res %0d exp 0 18", rsp_id, rsp_result); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_pick2 got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_id !== 2'd2 || rsp_result !== 16'd25) begin errors++; $display("FAIL fair_rsp2b got id %0d res %0d exp 2 25", rsp_id, rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_error();
        logic [15:0]     res;
        logic            err;
        logic [ID_W-1:0] id;
        bit              ok;
        int              timeouts;
        #1;
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_start got %0d exp 0", err_cnt); end
        run_op(3, 1'b1, 16'h7bff, 16'h7bff, res, err, id, ok);
        #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL err_op_timeout got %0b exp 1", ok); end
        checks++; if (err !== 1'b1 || id !== 2'd3) begin errors++; $display("FAIL err_flag got err %0b id %0d exp 1 3", err, id); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_one got %0d exp 1", err_cnt); end
        timeouts = 0;
        for (int n = 0; n < 254; n++) begin
            run_op(n % 4, 1'b1, 16'h7bff, 16'h7bff, res, err, id, ok);
            if (!ok) timeouts++;
        end
        #1;
        checks++; if (timeouts !== 0) begin errors++; $display("FAIL err_preload_timeouts got %0d exp 0", timeouts); end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_full got %0d exp 255", err_cnt); end
        run_op(0, 1'b1, 16'h7bff, 16'h7bff, res, err, id, ok);
        #1;
        checks++; if (err !== 1'b1 || err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got err %0b cnt %0d exp 1 255", err, err_cnt); end
        run_op(1, 1'b1, 16'h4000, 16'h4200, res, err, id, ok);
        #1;
        checks++; if (err !== 1'b0 || res !== 16'h4600 || err_cnt !== 8'd255) begin errors++; $display("FAIL err_clean_op got err %0b res %h cnt %0d exp 0 4600 255", err, res, err_cnt); end
    endtask

    task automatic test_reset_mid_calc();
        rsp_ready = 1'b1;
        req_mode[3] = 1'b0; req_a[63:48] = 16'd3; req_b[63:48] = 16'd4;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_grant got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_in_calc got busy %0b exp 1", busy); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_calc got valid %0b busy %0b cnt %0d exp 0 0 0", rsp_valid, busy, err_cnt); end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_rsp cycle %0d got valid %0b busy %0b exp 0 0", k, rsp_valid, busy); end
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr got %b exp 0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fp16();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_error();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
